retire_trace_checker: RTL

RETIRE_TRACE_CHECKER -- requirements
Module: retire_trace_checker

---
 rtl/retire_trace_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/retire_trace_checker.sv
// Compares DUT retire events, buffered in a FIFO, against a golden trace stream.
// Reports PASS on a matched final entry, FAIL on the first mismatch or on FIFO overflow.
module retire_trace_checker #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [69:0] inst_retire,
    input  logic        start,
    input  logic        golden_valid,
    input  logic [68:0] golden_data,
    input  logic        golden_last,
    output logic        golden_ready,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] match_count,
    output logic [68:0] fail_dut,
    output logic [68:0] fail_golden
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [1:0]       ERR_NONE     = 2'b00;
    localparam logic [1:0]       ERR_MISMATCH = 2'b01;
    localparam logic [1:0]       ERR_OVERFLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       match_count_q, match_count_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [68:0]       fail_dut_q, fail_dut_d;
    logic [68:0]       fail_golden_q, fail_golden_d;
    logic [68:0]       mem_q [FIFO_DEPTH];

    logic              retire_event;
    logic [68:0]       event_data;
    logic [68:0]       head;
    logic              fifo_full;
    logic              handshake;
    logic              overflow;
    logic              push_en;

    // Writes with rf_en set but targeting x0 do not change architectural state.
    assign retire_event = inst_retire[69] && (inst_retire[68:64] != 5'd0);
    assign event_data   = inst_retire[68:0];
    assign head         = mem_q[rd_ptr_q];
    assign fifo_full    = (count_q == DEPTH_C);

    assign golden_ready = (state_q == ST_RUN) && (count_q != '0);
    assign handshake    = golden_ready && golden_valid;
    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
    assign overflow     = (state_q == ST_RUN) && retire_event && fifo_full && !handshake;

    assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass        = (state_q == ST_PASS);
    assign err_code    = err_code_q;
    assign match_count = match_count_q;
    assign fail_dut    = fail_dut_q;
    assign fail_golden = fail_golden_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        match_count_d = match_count_q;
        err_code_d    = err_code_q;
        fail_dut_d    = fail_dut_q;
        fail_golden_d = fail_golden_q;
        push_en       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (handshake && (head != golden_data)) begin
                    state_d       = ST_FAIL;
                    err_code_d    = ERR_MISMATCH;
                    fail_dut_d    = head;
                    fail_golden_d = golden_data;
                end else if (overflow) begin
                    state_d       = ST_FAIL;
                    err_code_d    = ERR_OVERFLOW;
                    fail_dut_d    = event_data;
                    fail_golden_d = '0;
                end else begin
                    push_en = retire_event;
                    if (handshake) begin
                        rd_ptr_d      = rd_ptr_q + 1'b1;
                        match_count_d = match_count_q + 32'd1;
                        if (golden_last) begin
                            state_d = ST_PASS;
                        end
                    end
                    if (push_en) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (push_en && !handshake) begin
                        count_d = count_q + 1'b1;
                    end else if (!push_en && handshake) begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d       = ST_RUN;
                    rd_ptr_d      = '0;
                    wr_ptr_d      = '0;
                    count_d       = '0;
                    match_count_d = '0;
                    err_code_d    = ERR_NONE;
                    fail_dut_d    = '0;
                    fail_golden_d = '0;
                end
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            match_count_q <= '0;
            err_code_q    <= ERR_NONE;
            fail_dut_q    <= '0;
            fail_golden_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            match_count_q <= match_count_d;
            err_code_q    <= err_code_d;
            fail_dut_q    <= fail_dut_d;
            fail_golden_q <= fail_golden_d;
        end
    end

    // NOTE: the buffer storage is not reset; emptying is done by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= event_data;
        end
    end

endmodule
